// File: rtl/seven_seg_scanner_pkg.sv
// Shared constants and helpers for the 4-digit multiplexed 7-segment scanner.
package seven_seg_scanner_pkg;

    localparam int NUM_DIGITS    = 4;
    localparam int NIBBLE_W      = 4;
    localparam int DISP_W        = NUM_DIGITS * NIBBLE_W;
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

    // Defaults for a 100 MHz clock: 1 ms per digit, 5 us blanking guard.
    localparam int DEFAULT_DIV   = 100000;
    localparam int DEFAULT_GUARD = 500;

    typedef logic [1:0] digit_idx_t;

    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] digit_onehot(input digit_idx_t idx);
        return NUM_DIGITS'(1) << idx;
    endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Display-side bundle between a value producer and the scanner.
interface seven_seg_scanner_if;
    import seven_seg_scanner_pkg::*;

    logic [DISP_W-1:0]     value;
    logic                  load;
    logic [NUM_DIGITS-1:0] dp_in;
    logic [NUM_DIGITS-1:0] blank_mask;
    logic                  lz_en;
    logic [NIBBLE_W-1:0]   bin;
    logic [NUM_DIGITS-1:0] anode;
    logic                  dp;
    logic                  pending;

    modport master (
        output value, load, dp_in, blank_mask, lz_en,
        input  bin, anode, dp, pending
    );

    modport slave (
        input  value, load, dp_in, blank_mask, lz_en,
        output bin, anode, dp, pending
    );

endinterface

// File: rtl/seven_seg_scanner_tick.sv
// Digit-slot prescaler: counts 0..DIV-1 and flags the last cycle of each slot.
module tick_divider
    import seven_seg_scanner_pkg::*;
#(
    parameter int DIV = DEFAULT_DIV
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      tick,
    output logic [cnt_width(DIV)-1:0] count
);

    localparam int CNT_W = cnt_width(DIV);

    logic [CNT_W-1:0] count_reg;

    assign tick  = (count_reg == CNT_W'(DIV - 1));
    assign count = count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (tick) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexes a double-buffered 16-bit hex value onto a 4-digit common-anode display,
// with per-digit blanking, leading-zero suppression and an anti-ghosting guard interval.
module seven_seg_scanner
    import seven_seg_scanner_pkg::*;
#(
    parameter int DIV   = DEFAULT_DIV,
    parameter int GUARD = DEFAULT_GUARD
) (
    input  logic                clk,
    input  logic                rst,
    seven_seg_scanner_if.slave  bus
);

    localparam int CNT_W = cnt_width(DIV);

    logic                  tick;
    logic [CNT_W-1:0]      count;
    logic                  frame_wrap;
    logic                  in_guard;

    digit_idx_t            idx_reg, idx_next;
    logic [DISP_W-1:0]     disp_reg, disp_next;
    logic [DISP_W-1:0]     pend_reg, pend_next;
    logic                  pending_reg, pending_next;

    logic [NUM_DIGITS-1:0] lz_dark;
    logic [NUM_DIGITS-1:0] dark;
    logic [NUM_DIGITS-1:0] anode_reg, anode_next;
    logic [NIBBLE_W-1:0]   bin_reg, bin_next;
    logic                  dp_reg, dp_next;

    tick_divider #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .count (count)
    );

    assign frame_wrap = tick && (idx_reg == digit_idx_t'(NUM_DIGITS - 1));
    assign in_guard   = (int'(count) < GUARD);

    // Digit 0 is exempt from zero suppression so an all-zero value still shows "0".
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dark
        if (gi == 0) begin : g_first
            assign lz_dark[gi] = 1'b0;
        end else begin : g_upper
            assign lz_dark[gi] = bus.lz_en && (disp_reg[DISP_W-1:NIBBLE_W*gi] == '0);
        end
        assign dark[gi] = bus.blank_mask[gi] | in_guard | lz_dark[gi];
    end

    // Buffer update: a load on the wrap cycle bypasses straight to the display.
    always_comb begin
        idx_next     = idx_reg;
        disp_next    = disp_reg;
        pend_next    = pend_reg;
        pending_next = pending_reg;

        if (tick) begin
            idx_next = idx_reg + 1'b1;
        end

        if (frame_wrap) begin
            if (bus.load) begin
                disp_next    = bus.value;
                pending_next = 1'b0;
            end else if (pending_reg) begin
                disp_next    = pend_reg;
                pending_next = 1'b0;
            end
        end else if (bus.load) begin
            pend_next    = bus.value;
            pending_next = 1'b1;
        end
    end

    always_comb begin
        anode_next = ~(digit_onehot(idx_reg) & ~dark);
        bin_next   = disp_reg[{idx_reg, 2'b00} +: NIBBLE_W];
        dp_next    = ~(bus.dp_in[idx_reg] & ~dark[idx_reg]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg     <= '0;
            disp_reg    <= '0;
            pend_reg    <= '0;
            pending_reg <= 1'b0;
            anode_reg   <= ANODE_OFF;
            bin_reg     <= '0;
            dp_reg      <= 1'b1;
        end else begin
            idx_reg     <= idx_next;
            disp_reg    <= disp_next;
            pend_reg    <= pend_next;
            pending_reg <= pending_next;
            anode_reg   <= anode_next;
            bin_reg     <= bin_next;
            dp_reg      <= dp_next;
        end
    end

    assign bus.anode   = anode_reg;
    assign bus.bin     = bin_reg;
    assign bus.dp      = dp_reg;
    assign bus.pending = pending_reg;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner with DIV=8, GUARD=2 (32-cycle frames).
module tb_seven_seg_scanner;

    localparam int DIV   = 8;
    localparam int GUARD = 2;
    localparam int FRAME = 4 * DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tcyc = 0;

    int checks = 0;
    int errors = 0;

    int multi_low_cnt = 0;
    int dp_dark_cnt   = 0;
    int ones_cnt      = 0;
    bit mon_ones      = 1'b0;

    seven_seg_scanner_if sif ();

    seven_seg_scanner #(.DIV(DIV), .GUARD(GUARD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    always #5 clk = ~clk;

    // Cycles since reset release; after edge k the outputs reflect prescaler state k-1.
    always @(posedge clk) begin
        if (rst) tcyc <= 0;
        else     tcyc <= tcyc + 1;
    end

    always @(negedge clk) begin
        if ($countones(~sif.anode) > 1) multi_low_cnt++;
        if (sif.dp == 1'b0 && sif.anode == 4'b1111) dp_dark_cnt++;
        if (mon_ones && sif.anode != 4'b1111 && sif.bin == 4'h1) ones_cnt++;
    end

    typedef struct {
        logic [15:0] value;
        logic        lz;
        logic [3:0]  blank;
        logic [3:0]  dpin;
        logic [15:0] anode;   // expected lit-cycle anode per digit, digit d at [4d+3:4d]
        logic [3:0]  dp;      // expected lit-cycle dp per digit
    } vec_t;

    typedef struct {
        logic [3:0] anode;
        logic [3:0] bin;
        logic       dp;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[5];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (tcyc=%0d)", name, act, req, tcyc);
        end
    endtask

    task automatic wait_pos(input int p);
        bit found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            @(negedge clk);
            if (tcyc % FRAME == p) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL wait_pos: timed out at tcyc=%0d waiting for pos %0d", tcyc, p);
        end
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = exp_q.pop_front();
        check({name, "_anode"}, 16'(sif.anode), 16'(e.anode));
        check({name, "_bin"},   16'(sif.bin),   16'(e.bin));
        check({name, "_dp"},    16'(sif.dp),    16'(e.dp));
    endtask

    initial begin
        sif.value      = '0;
        sif.load       = 1'b0;
        sif.dp_in      = '0;
        sif.blank_mask = '0;
        sif.lz_en      = 1'b0;

        vecs[0] = '{16'h12AF, 1'b0, 4'b0000, 4'b0000, 16'h7BDE, 4'b1111};
        vecs[1] = '{16'h0040, 1'b1, 4'b0000, 4'b0000, 16'hFFDE, 4'b1111};
        vecs[2] = '{16'h0000, 1'b1, 4'b0000, 4'b0000, 16'hFFFE, 4'b1111};
        vecs[3] = '{16'h12AF, 1'b0, 4'b0100, 4'b0101, 16'h7FDE, 4'b1110};
        vecs[4] = '{16'h0F00, 1'b1, 4'b0000, 4'b1111, 16'hFBDE, 4'b1000};

        // Reset values, then first lit digit at cycle GUARD+1.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_anode",   16'(sif.anode),   16'h000F);
        check("rst_dp",      16'(sif.dp),      16'h0001);
        check("rst_bin",     16'(sif.bin),     16'h0000);
        check("rst_pending", 16'(sif.pending), 16'h0000);
        rst = 1'b0;
        begin
            bit lit = 1'b0;
            for (int i = 0; i < 40 && !lit; i++) begin
                @(negedge clk);
                if (sif.anode != 4'b1111) lit = 1'b1;
            end
            check("first_lit_cycle", 16'(tcyc), 16'(GUARD + 1));
            check("first_lit_anode", 16'(sif.anode), 16'hE);
        end
        $display("reset: first lit digit at cycle %0d", tcyc);

        // Pending flag lifecycle and guard darkness over a full frame.
        wait_pos(0);
        sif.value = 16'h12AF;
        sif.load  = 1'b1;
        @(negedge clk);
        sif.load  = 1'b0;
        check("pending_set", 16'(sif.pending), 16'h0001);
        wait_pos(0);
        check("pending_clr_at_wrap", 16'(sif.pending), 16'h0000);
        begin
            int dark_cycles = 0;
            for (int i = 0; i < FRAME; i++) begin
                @(negedge clk);
                if (sif.anode == 4'b1111) dark_cycles++;
            end
            check("dark_cycles_per_frame", 16'(dark_cycles), 16'(4 * GUARD));
        end
        $display("frame: value 12AF pending cleared at wrap");

        // Table vectors: load at frame start, check guard and lit cycles of the next frame.
        for (int v = 0; v < 5; v++) begin
            sif.lz_en      = vecs[v].lz;
            sif.blank_mask = vecs[v].blank;
            sif.dp_in      = vecs[v].dpin;
            wait_pos(0);
            sif.value = vecs[v].value;
            sif.load  = 1'b1;
            for (int d = 0; d < 4; d++) begin
                exp_q.push_back('{4'b1111, vecs[v].value[4*d +: 4], 1'b1});
                exp_q.push_back('{vecs[v].anode[4*d +: 4], vecs[v].value[4*d +: 4], vecs[v].dp[d]});
            end
            @(negedge clk);
            sif.load = 1'b0;
            wait_pos(0);
            for (int d = 0; d < 4; d++) begin
                wait_pos(8 * d + 1);
                pop_check($sformatf("v%0d_d%0d_guard", v, d));
                wait_pos(8 * d + 5);
                pop_check($sformatf("v%0d_d%0d_lit", v, d));
            end
            $display("vec %0d: value=%h lz=%b blank=%b dp_in=%b checked", v,
                     vecs[v].value, vecs[v].lz, vecs[v].blank, vecs[v].dpin);
        end

        // Last load in a frame wins; a load on the wrap cycle bypasses the buffer.
        sif.lz_en      = 1'b0;
        sif.blank_mask = '0;
        sif.dp_in      = '0;
        mon_ones       = 1'b1;
        wait_pos(2);
        sif.value = 16'h1111;
        sif.load  = 1'b1;
        @(negedge clk);
        sif.load  = 1'b0;
        wait_pos(10);
        sif.value = 16'h2222;
        sif.load  = 1'b1;
        @(negedge clk);
        sif.load  = 1'b0;
        wait_pos(0);
        for (int d = 0; d < 4; d++) begin
            wait_pos(8 * d + 5);
            check($sformatf("lastwins_d%0d_bin", d), 16'(sif.bin), 16'h2);
            check($sformatf("lastwins_d%0d_anode", d), 16'(sif.anode), 16'(~(4'b0001 << d) & 4'hF));
        end
        wait_pos(FRAME - 1);
        sif.value = 16'h5678;
        sif.load  = 1'b1;
        @(negedge clk);
        sif.load  = 1'b0;
        check("wrap_load_pending", 16'(sif.pending), 16'h0000);
        wait_pos(5);
        check("wrap_load_d0_bin",   16'(sif.bin),   16'h8);
        check("wrap_load_d0_anode", 16'(sif.anode), 16'hE);
        wait_pos(13);
        check("wrap_load_d1_bin",   16'(sif.bin),   16'h7);
        mon_ones = 1'b0;
        check("ones_never_shown", 16'(ones_cnt), 16'h0000);
        $display("buffer: last load wins, wrap-cycle load shown in next slot");

        // Reset mid-frame discards a pending value.
        wait_pos(0);
        sif.value = 16'hBEEF;
        sif.load  = 1'b1;
        @(negedge clk);
        sif.load  = 1'b0;
        check("midrst_pending_before", 16'(sif.pending), 16'h0001);
        wait_pos(12);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_anode",   16'(sif.anode),   16'h000F);
        check("midrst_dp",      16'(sif.dp),      16'h0001);
        check("midrst_bin",     16'(sif.bin),     16'h0000);
        check("midrst_pending", 16'(sif.pending), 16'h0000);
        rst = 1'b0;
        wait_pos(0);
        check("midrst_pending_after_wrap", 16'(sif.pending), 16'h0000);
        for (int d = 0; d < 4; d++) begin
            wait_pos(8 * d + 5);
            check($sformatf("midrst_d%0d_bin", d), 16'(sif.bin), 16'h0);
            check($sformatf("midrst_d%0d_anode", d), 16'(sif.anode), 16'(~(4'b0001 << d) & 4'hF));
        end
        $display("reset mid-frame: pending value discarded");

        check("one_anode_max", 16'(multi_low_cnt), 16'h0000);
        check("dp_only_when_lit", 16'(dp_dark_cnt), 16'h0000);
        check("scoreboard_drained", 16'(exp_q.size()), 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
